// File: rtl/store_write_buffer_if.sv
// Processor-side and memory-side signals of the posted-store buffer.
// The buffer connects through slave; the core/memory environment through master.
interface store_write_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_we;
    logic              cpu_re;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_write_buffer.sv
// Posted-store FIFO: stores retire one per cycle, loads own the port and forward hits.
// Optional STORE_BUF_COALESCE_EN merges a store into the youngest entry of the same word.
module store_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   CLK,
    input  logic                   reset,
    store_write_buffer_if.slave    bus,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  youngest;
    logic              full;
    logic              hit;
    logic [DATA_W-1:0] fwd;
    logic              claim;
    logic              drain;
    logic              coal;
    logic              enq;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign youngest = tail - PTR_W'(1);

    // Oldest to youngest, so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit = 1'b0;
        fwd = '0;
        idx = head;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (CNT_W'(k) < count &&
                addr_q[idx][ADDR_W-1:2] == bus.cpu_addr[ADDR_W-1:2]) begin
                hit = 1'b1;
                fwd = data_q[idx];
            end
        end
    end

    // A combined we/re request still claims the port, so it never drains.
    assign claim = bus.cpu_re && (bus.cpu_we || !hit);
    assign drain = !empty && !claim;

`ifdef STORE_BUF_COALESCE_EN
    assign coal = bus.cpu_we && !empty &&
                  addr_q[youngest][ADDR_W-1:2] == bus.cpu_addr[ADDR_W-1:2] &&
                  !(count == CNT_W'(1) && drain);
`else
    assign coal = 1'b0;
`endif

    assign enq           = bus.cpu_we && !full && !coal;
    assign bus.cpu_stall = bus.cpu_we && full && !coal;
    assign bus.mem_we    = drain;
    assign bus.mem_addr  = (claim || empty) ? bus.cpu_addr : addr_q[head];
    assign bus.mem_wdata = data_q[head];
    assign bus.cpu_rdata = hit ? fwd : bus.mem_rdata;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)
                tail <= tail + PTR_W'(1);
            if (drain)
                head <= head + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(drain);
        end
    end

    // Payload needs no reset: validity is carried by head/count.
    always_ff @(posedge CLK) begin
        if (enq) begin
            addr_q[tail] <= bus.cpu_addr;
            data_q[tail] <= bus.cpu_wdata;
        end
        if (coal)
            data_q[youngest] <= bus.cpu_wdata;
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed table, hand sequences, random vs queue model.
// Build with +define+STORE_BUF_COALESCE_EN to check the merging variant.
module tb_store_write_buffer;
    localparam int DEPTH = 4;
`ifdef STORE_BUF_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  cnt;
        logic        stall;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       empty;
    logic [2:0] count;

    logic [31:0] mem [256] = '{default: 32'hDEAD_0000};
    logic [31:0] ref_mem [256] = '{default: 32'hDEAD_0000};
    int          w30 = 0;

    ent_t q[$];
    vec_t vt [11];
    int   tests = 0;
    int   fails = 0;

    store_write_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus),
        .empty (empty),
        .count (count)
    );

    always #5 CLK = ~CLK;

    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    always @(posedge CLK) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
            if (bus.mem_addr == 32'h30)
                w30 <= w30 + 1;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        bus.cpu_we    = we;
        bus.cpu_re    = re;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        #1;
    endtask

    // Queue model: checks the current cycle's outputs, then applies the edge.
    task automatic model(input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        int          n = q.size();
        bit          hit = 1'b0;
        logic [31:0] hd = '0;
        bit          claim, drain, coal, full;
        logic [31:0] ma;
        for (int i = n - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == a[31:2]) begin
                hit = 1'b1;
                hd  = q[i].d;
                break;
            end
        end
        claim = re && (we || !hit);
        drain = (n > 0) && !claim;
        coal  = COAL && we && n > 0 && q[n-1].a[31:2] == a[31:2] && !(n == 1 && drain);
        full  = (n == DEPTH);
        ma    = (claim || n == 0) ? a : q[0].a;
        chk("m_count", 32'(count), 32'(n));
        chk("m_empty", 32'(empty), 32'(n == 0));
        chk("m_stall", 32'(bus.cpu_stall), 32'(we && full && !coal));
        chk("m_mem_we", 32'(bus.mem_we), 32'(drain));
        chk("m_mem_addr", bus.mem_addr, ma);
        if (drain)
            chk("m_mem_wdata", bus.mem_wdata, q[0].d);
        if (re && !we)
            chk("m_rdata", bus.cpu_rdata, hit ? hd : ref_mem[a[9:2]]);
        if (drain) begin
            ref_mem[q[0].a[9:2]] = q[0].d;
            void'(q.pop_front());
        end
        if (coal)
            q[q.size()-1].d = d;
        else if (we && !full)
            q.push_back('{a: a, d: d});
    endtask

    task automatic step(input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d);
        drive(we, re, a, d);
        model(we, re, a, d);
    endtask

    task automatic flush();
        repeat (DEPTH + 2) step(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        int  bad;
        int  tries;
        int  w30_0;
        bit  st;
        bit  hold;
        logic we, re;
        logic [31:0] a;

        // Three plain stores, then a store pair to one word and reloads of it.
        vt[0]  = '{1, 0, 32'h10, 32'hA, 0, 0, 0, 32'h10, 0, 0, 0};
        vt[1]  = '{1, 0, 32'h14, 32'hB, 1, 0, 1, 32'h10, 32'hA, 0, 0};
        vt[2]  = '{1, 0, 32'h18, 32'hC, 1, 0, 1, 32'h14, 32'hB, 0, 0};
        vt[3]  = '{0, 0, 32'h00, 32'h0, 1, 0, 1, 32'h18, 32'hC, 0, 0};
        vt[4]  = '{0, 0, 32'h00, 32'h0, 0, 0, 0, 32'h00, 0, 0, 0};
        vt[5]  = '{1, 1, 32'h20, 32'h11, 0, 0, 0, 32'h20, 0, 0, 0};
        vt[6]  = '{1, 1, 32'h20, 32'h22, 1, 0, 0, 32'h20, 0, 0, 0};
        vt[7]  = '{0, 1, 32'h20, 32'h0, COAL ? 3'd1 : 3'd2, 0, 1, 32'h20,
                   COAL ? 32'h22 : 32'h11, 1, 32'h22};
        vt[8]  = '{0, 0, 32'h00, 32'h0, COAL ? 3'd0 : 3'd1, 0, !COAL,
                   COAL ? 32'h0 : 32'h20, 32'h22, 0, 0};
        vt[9]  = '{0, 0, 32'h00, 32'h0, 0, 0, 0, 32'h00, 0, 0, 0};
        vt[10] = '{0, 1, 32'h20, 32'h0, 0, 0, 0, 32'h20, 0, 1, 32'h22};

        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        repeat (2) @(negedge CLK);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(vt[i].stall));
            chk($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vt[i].mwe));
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vt[i].maddr);
            if (vt[i].mwe)
                chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vt[i].mwdata);
            if (vt[i].chk_rd)
                chk($sformatf("v%0d_rdata", i), bus.cpu_rdata, vt[i].rd);
            model(vt[i].we, vt[i].re, vt[i].addr, vt[i].wdata);
        end

        // Port held by loads: fill to full, stall, then release and retry.
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 32'(4 * i), 32'h50 + 32'(i));
        drive(1'b1, 1'b1, 32'h10, 32'h54);
        chk("full_count", 32'(count), 32'd4);
        chk("full_stall", 32'(bus.cpu_stall), 32'd1);
        model(1'b1, 1'b1, 32'h10, 32'h54);
        drive(1'b1, 1'b0, 32'h10, 32'h54);
        chk("rel_stall", 32'(bus.cpu_stall), 32'd1);
        chk("rel_mem_we", 32'(bus.mem_we), 32'd1);
        model(1'b1, 1'b0, 32'h10, 32'h54);
        drive(1'b1, 1'b0, 32'h10, 32'h54);
        chk("retry_stall", 32'(bus.cpu_stall), 32'd0);
        chk("retry_count", 32'(count), 32'd3);
        model(1'b1, 1'b0, 32'h10, 32'h54);
        flush();
        chk("full_mem0", mem[0], 32'h50);
        chk("full_mem4", mem[4], 32'h54);

        // Twelve stores wrapping the pointers under intermittent loads.
        for (int i = 0; i < 12; i++) begin
            tries = 0;
            re = (i % 3) != 2;
            do begin
                drive(1'b1, re, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
                st = bus.cpu_stall;
                model(1'b1, re, 32'h200 + 32'(4 * i), 32'h1000 + 32'(i));
                re = 1'b0;
                tries++;
            end while (st && tries < 8);
            if (st)
                chk("wrap_retry_timeout", 32'(st), 32'd0);
        end
        flush();
        for (int i = 0; i < 12; i++)
            chk($sformatf("wrap_mem%0d", i), mem[128 + i], 32'h1000 + 32'(i));

        // Asynchronous reset with three stores pending.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 32'h3C0 + 32'(4 * i), 32'h77 + 32'(i));
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        chk("pre_rst_count", 32'(count), 32'd3);
        chk("pre_rst_mem_we", 32'(bus.mem_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        q.delete();
        @(negedge CLK);
        reset = 1'b0;
        flush();
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst_nowrite%0d", i), mem[240 + i], 32'hDEAD_0000);

        // Two stores to one word while the port is held.
        w30_0 = w30;
        step(1'b1, 1'b1, 32'h30, 32'h1);
        step(1'b1, 1'b1, 32'h30, 32'h2);
        drive(1'b0, 1'b1, 32'h40, 32'h0);
        chk("coal_count", 32'(count), COAL ? 32'd1 : 32'd2);
        model(1'b0, 1'b1, 32'h40, 32'h0);
        flush();
        chk("coal_writes", 32'(w30 - w30_0), COAL ? 32'd1 : 32'd2);
        chk("coal_mem", mem[12], 32'h2);

        // Random traffic over a small address window to force hits and stalls.
        hold = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0)
                hold = !hold;
            we = 1'($urandom_range(1));
            re = hold || ($urandom_range(3) == 0);
            a  = 32'h100 + 32'(4 * $urandom_range(7));
            step(we, re, a, $urandom);
        end
        flush();
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i])
                bad++;
        chk("rand_mem_image", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Posted-store buffer between the single-cycle processor's data-memory port and the data memory.
- Stores are accepted in one cycle and retired to memory later, one per cycle, over the single memory port.
- Loads take the port first; loads that hit a pending store are forwarded from the buffer.
- Lets slower or shared memory back the processor without stalling on every store.

Parameters:
DEPTH, 4, number of buffered stores (power of 2, >= 2)
ADDR_W, 32, byte-address width
DATA_W, 32, word width

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_we  in  1  processor store request (memWrite)
cpu_re  in  1  processor load request
cpu_addr  in  ADDR_W  processor byte address (word aligned)
cpu_wdata  in  DATA_W  store data
cpu_rdata  out  DATA_W  load data (combinational)
cpu_stall  out  1  store not accepted this cycle; processor holds PC and retries
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory combinational read data
empty  out  1  no pending stores
count  out  $clog2(DEPTH)+1  pending-store count

Behaviour:
- Storage: circular FIFO of (addr, data) entries with head/tail pointers mod DEPTH; wrap-around is silent. full = (count == DEPTH).
- Address compare uses only addr[ADDR_W-1:2].
- Reset (asynchronous): head = tail = count = 0; empty = 1; mem_we = 0; cpu_stall = 0; buffered stores are discarded. Reset mid-drain aborts the drain; no partial write is issued after reset rises.
- Store accept:
  - cpu_we & !full: enqueue at tail on the clock edge; cpu_stall = 0.
  - cpu_we & full: cpu_stall = 1 (combinational); nothing enqueued.
- Load:
  - Search all valid entries, youngest to oldest.
  - Hit: cpu_rdata = data of youngest match; memory port not used.
  - Miss: mem_addr = cpu_addr, mem_we = 0, cpu_rdata = mem_rdata.
  - Zero-cycle latency, no stall.
- Drain: when count > 0 and no load-miss this cycle:
  - mem_we = 1, mem_addr/mem_wdata = head entry.
  - head advances at the clock edge.
  - A load-miss blocks the drain that cycle; a load-hit does not.
- Idle: mem_we = 0; mem_addr = head addr (or cpu_addr if count = 0); mem_wdata = head data.
- Simultaneous events:
  - Enqueue + drain in the same cycle: count unchanged.
  - Full + store + drain: stall still asserted that cycle (full evaluated before the edge); the retried store is accepted next cycle.
- cpu_we & cpu_re together: illegal; treated as a store; cpu_rdata undefined.
- Ordering: memory writes issue strictly in program order.
- A load issued after a store to the same word always returns the stored value, whether it is buffered or already drained.

Optional Feature:
STORE_BUF_COALESCE_EN
- Defined: a store whose word address equals the youngest entry's address overwrites that entry's data in place; count is unchanged and no stall occurs even when full.
  - Exception: if that entry is being drained this cycle (count == 1 and drain active), the store is enqueued normally.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then 3 stores (0x10 = 0xA, 0x14 = 0xB, 0x18 = 0xC) with cpu_re = 0 -> count peaks at 1 (store and drain overlap); mem_we pulses write 0xA, 0xB, 0xC in order; empty = 1 afterwards.
- Hold a load-miss to 0x40 for 6 cycles while issuing 5 stores to 0x0..0x10:
  - count reaches 4 (DEPTH 4) and the 5th store sees cpu_stall = 1 with no enqueue.
  - Release the load -> drain resumes; the retried store is accepted next cycle.
- Store 0x20 = 0x11, then 0x20 = 0x22, then load 0x20 with memory blocked by load-misses -> cpu_rdata = 0x22 (youngest match); no mem read of 0x20.
- Fill to full with addresses wrapping the pointers twice (12 stores under intermittent loads) -> memory contents match program order; no lost or duplicated writes.
- Assert reset with count = 3 -> count = 0, mem_we = 0 immediately (asynchronous); none of the pending writes reach memory.
- With STORE_BUF_COALESCE_EN: hold a load-miss, then store 0x30 = 1 and 0x30 = 2 -> count = 1; the single drained write is 0x30 = 2. Without the macro -> count = 2; two writes, 1 then 2.
